// File: rtl/fb_arbiter.sv
// fb_fifo: small generic FIFO with one registered read pointer and a combinational head.
// Latency: an entry pushed at one edge is visible on head_dat right after that edge.
// Backpressure: none internal; the caller gates push and pop.
module fb_fifo #(
    parameter int W  = 8,
    parameter int D  = 4,
    parameter int CW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count
);
    localparam int PW = (D > 1) ? $clog2(D) : 1;

    logic [W-1:0]  mem [D];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop)  rd_ptr <= inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

// fb_arbiter: shares one single-port frame-buffer RAM between scan-out reads and a FIFO-fed writer / clear engine.
// Latency: read slot to pixel_rgb is 2 clk edges; queued writes retire in the next free write slot.
// Backpressure: registered wr_ready drops when the FIFO is full or a clear is pending or running.
module fb_arbiter #(
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int SCALE_SH = 2,
    parameter int ADDR_W   = 15,
    parameter int FIFO_D   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ptick,
    input  logic              active,
    input  logic [9:0]        xpos,
    input  logic [9:0]        ypos,
    output logic [2:0]        pixel_rgb,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [2:0]        wr_data,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [2:0]        mem_wdata,
    input  logic [2:0]        mem_rdata,
    output logic              addr_err,
    output logic              frame_start
);
    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        dat;
    } wr_ent_t;

    localparam int                CW        = $clog2(FIFO_D + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] rd_addr;
    wr_ent_t           push_ent;
    wr_ent_t           head;
    logic [CW-1:0]     fifo_cnt;
    logic [CW-1:0]     fifo_cnt_nxt;
    logic              read_slot;
    logic              push;
    logic              pop;
    logic              clr_wr;
    logic              drop;
    logic              rd_d;
    logic              blank_d;
    logic              fs_seen;
    logic              origin;

    assign read_slot    = !ptick && active;
    assign rd_addr      = ADDR_W'(ypos >> SCALE_SH) * ADDR_W'(FB_W) + ADDR_W'(xpos >> SCALE_SH);
    assign push         = wr_valid && wr_ready;
    assign push_ent     = {wr_addr, wr_data};
    assign fifo_cnt_nxt = fifo_cnt + CW'(push) - CW'(pop);
    assign origin       = (xpos == 10'd0) && (ypos == 10'd0);
    assign frame_start  = rst_n && origin && !ptick && !fs_seen;

    fb_fifo #(
        .W  ($bits(wr_ent_t)),
        .D  (FIFO_D),
        .CW (CW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .head_dat (head),
        .count    (fifo_cnt)
    );

    // The RAM port is steered combinationally so the read address meets the
    // synchronous RAM in the slot itself; reset forces the port quiet at once.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        pop       = 1'b0;
        clr_wr    = 1'b0;
        drop      = 1'b0;
        if (rst_n) begin
            if (read_slot) begin
                mem_addr = rd_addr;
            end else if (state == CLEAR) begin
                mem_we   = 1'b1;
                mem_addr = clr_cnt;
                clr_wr   = 1'b1;
            end else if (fifo_cnt != '0) begin
                pop = 1'b1;
                if (head.addr <= LAST_ADDR) begin
                    mem_we    = 1'b1;
                    mem_addr  = head.addr;
                    mem_wdata = head.dat;
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req) state_nxt = DRAIN;
            DRAIN:   if (fifo_cnt == '0) state_nxt = CLEAR;
            CLEAR:   if (clr_wr && clr_cnt == LAST_ADDR) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clr_cnt   <= '0;
            wr_ready  <= 1'b0;
            clr_busy  <= 1'b0;
            addr_err  <= 1'b0;
            pixel_rgb <= '0;
            rd_d      <= 1'b0;
            blank_d   <= 1'b0;
            fs_seen   <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_busy <= (state_nxt != IDLE);
            wr_ready <= (fifo_cnt_nxt < CW'(FIFO_D)) && (state_nxt == IDLE);
            if (clr_wr) clr_cnt <= (clr_cnt == LAST_ADDR) ? '0 : clr_cnt + ADDR_W'(1);
            if (drop) addr_err <= 1'b1;
            rd_d    <= read_slot;
            blank_d <= !active;
            if (rd_d)         pixel_rgb <= mem_rdata;
            else if (blank_d) pixel_rgb <= '0;
            // Re-arms only once the beam leaves the origin, so one pulse per frame.
            if (origin && !ptick) fs_seen <= 1'b1;
            else if (!origin)     fs_seen <= 1'b0;
        end
    end
endmodule
